// File: rtl/gcd_operand_sequencer_if.sv
// Handshake and engine-side signal bundle for the GCD operand sequencer.
// The sequencer sits on the slave side; the producer/engine/consumer environment is the master.
interface gcd_operand_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             eng_start;
    logic             eng_sel_b;
    logic [WIDTH-1:0] eng_data;
    logic             eng_done;
    logic [WIDTH-1:0] eng_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic             out_err;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, eng_done, eng_result, out_ready,
        output in_ready, eng_start, eng_sel_b, eng_data, out_valid, out_gcd, out_err, busy
    );

    modport master (
        output in_valid, in_a, in_b, eng_done, eng_result, out_ready,
        input  in_ready, eng_start, eng_sel_b, eng_data, out_valid, out_gcd, out_err, busy
    );
endinterface

// File: rtl/gcd_operand_sequencer.sv
// Operand sequencer for the GCD engine: buffers operand pairs, loads A then B into the
// engine, waits for done (bounded by a timeout) and holds the result until accepted.
// Zero operands never reach the engine because it would not terminate on them.
module gcd_operand_sequencer #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic                    clk,
    input logic                    rst_n,
    gcd_operand_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        WAIT,
        OUT
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    wrPtr_q, rdPtr_q;
    logic [WIDTH-1:0] memA [DEPTH];
    logic [WIDTH-1:0] memB [DEPTH];
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             err_q, err_d;
    logic [CW-1:0]    timeCnt_q, timeCnt_d;

    logic             fifoEmpty;
    logic             fifoFull;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] headA;
    logic [WIDTH-1:0] headB;

    logic             engStart;
    logic             engSelB;
    logic [WIDTH-1:0] engData;
    logic             outValid;
    logic [WIDTH-1:0] outGcd;
    logic             outErr;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
    assign push      = bus.in_valid && !fifoFull;
    // The output register is only ever occupied in OUT, so being in IDLE means it is free.
    assign pop       = (state_q == IDLE) && !fifoEmpty;
    assign headA     = memA[rdPtr_q[AW-1:0]];
    assign headB     = memB[rdPtr_q[AW-1:0]];

    // Operand storage; contents are don't-care until a push writes them.
    always_ff @(posedge clk) begin
        if (push) begin
            memA[wrPtr_q[AW-1:0]] <= bus.in_a;
            memB[wrPtr_q[AW-1:0]] <= bus.in_b;
        end
    end

    // FIFO pointers advance independently so a push and pop can share a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + PW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
        end
    end

    // State and run registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opA_q     <= '0;
            opB_q     <= '0;
            gcd_q     <= '0;
            err_q     <= 1'b0;
            timeCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            gcd_q     <= gcd_d;
            err_q     <= err_d;
            timeCnt_q <= timeCnt_d;
        end
    end

    // Next-state logic: zero filtering on pop, timeout bookkeeping, done capture.
    always_comb begin
        state_d   = state_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        gcd_d     = gcd_q;
        err_d     = err_q;
        timeCnt_d = timeCnt_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    opA_d = headA;
                    opB_d = headB;
                    if ((headA == '0) && (headB == '0)) begin
                        gcd_d   = '0;
                        err_d   = 1'b1;
                        state_d = OUT;
                    end else if (headA == '0) begin
                        gcd_d   = headB;
                        err_d   = 1'b0;
                        state_d = OUT;
                    end else if (headB == '0) begin
                        gcd_d   = headA;
                        err_d   = 1'b0;
                        state_d = OUT;
                    end else begin
                        state_d = LOAD_A;
                    end
                end
            end
            LOAD_A: begin
                state_d = LOAD_B;
            end
            LOAD_B: begin
                timeCnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (bus.eng_done) begin
                    gcd_d   = bus.eng_result;
                    err_d   = 1'b0;
                    state_d = OUT;
                end else if (timeCnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    gcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = OUT;
                end else if (timeCnt_q != '1) begin
                    timeCnt_d = timeCnt_q + CW'(1);
                end
            end
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode purely from registered state, so nothing combinational reaches the ports.
    always_comb begin
        engStart = 1'b0;
        engSelB  = 1'b0;
        engData  = '0;
        outValid = 1'b0;
        outGcd   = '0;
        outErr   = 1'b0;
        case (state_q)
            LOAD_A: begin
                engStart = 1'b1;
                engData  = opA_q;
            end
            LOAD_B: begin
                engStart = 1'b1;
                engSelB  = 1'b1;
                engData  = opB_q;
            end
            OUT: begin
                outValid = 1'b1;
                outGcd   = gcd_q;
                outErr   = err_q;
            end
            default: begin
                engStart = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = !fifoFull;
    assign bus.eng_start = engStart;
    assign bus.eng_sel_b = engSelB;
    assign bus.eng_data  = engData;
    assign bus.out_valid = outValid;
    assign bus.out_gcd   = outGcd;
    assign bus.out_err   = outErr;
    assign bus.busy      = (state_q != IDLE) || !fifoEmpty;
endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Directed bench for the GCD operand sequencer with a behavioural GCD engine model.
module tb_gcd_operand_sequencer;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    gcd_operand_sequencer_if #(.WIDTH(WIDTH)) bus();

    gcd_operand_sequencer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Free-running clock and cycle index.
    always #5 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    // Engine model: loads A/B on eng_start, raises done after engDelay cycles and keeps it
    // high until the next B load; operand A equal to stuckA never completes.
    int               engDelay = 10;
    logic [WIDTH-1:0] stuckA   = '0;
    logic [WIDTH-1:0] engA, engB;
    logic             engRun;
    int               engCnt;

    function automatic logic [WIDTH-1:0] tbGcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.eng_done   <= 1'b0;
            bus.eng_result <= '0;
            engRun         <= 1'b0;
            engCnt         <= 0;
            engA           <= '0;
            engB           <= '0;
        end else begin
            if (bus.eng_start && !bus.eng_sel_b) engA <= bus.eng_data;
            if (bus.eng_start && bus.eng_sel_b) begin
                engB         <= bus.eng_data;
                bus.eng_done <= 1'b0;
                engRun       <= (engA != stuckA);
                engCnt       <= engDelay;
            end else if (engRun) begin
                if (engCnt <= 1) begin
                    engRun         <= 1'b0;
                    bus.eng_done   <= 1'b1;
                    bus.eng_result <= tbGcd(engA, engB);
                end else begin
                    engCnt <= engCnt - 1;
                end
            end
        end
    end

    // Monitor on the falling edge: engine loads, out_valid rise time, accepted results.
    logic [WIDTH-1:0] loadData[$];
    logic             loadSel[$];
    int               loadCyc[$];
    logic [WIDTH:0]   outQ[$];
    int               lastLoadBCyc = 0;
    int               validRiseCyc = 0;
    logic             prevValid    = 1'b0;

    always @(negedge clk) begin
        if (bus.eng_start) begin
            loadData.push_back(bus.eng_data);
            loadSel.push_back(bus.eng_sel_b);
            loadCyc.push_back(cycle);
            if (bus.eng_sel_b) lastLoadBCyc = cycle;
        end
        if (bus.out_valid && !prevValid) validRiseCyc = cycle;
        prevValid = bus.out_valid;
        if (bus.out_valid && bus.out_ready) outQ.push_back({bus.out_err, bus.out_gcd});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one pair and wait (bounded) until the sequencer takes it.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit accepted;
        accepted = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 500 && !accepted; i++) begin
            @(negedge clk);
            if (bus.in_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checkOutput("push_accept", 32'(accepted), 32'd1);
    endtask

    task automatic waitOutputs(input int n);
        for (int i = 0; i < 2000 && outQ.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        if (outQ.size() < n) checkOutput("wait_outputs", outQ.size(), n);
    endtask

    task automatic checkResult(input string tag, input logic [WIDTH-1:0] expGcd, input logic expErr);
        logic [WIDTH:0] got;
        if (outQ.size() == 0) begin
            checkOutput({tag, "_present"}, outQ.size(), 1);
        end else begin
            got = outQ.pop_front();
            checkOutput(tag, 32'(got), 32'({expErr, expGcd}));
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        checkOutput({tag, "_eng_start"}, 32'(bus.eng_start), 32'd0);
        checkOutput({tag, "_eng_sel_b"}, 32'(bus.eng_sel_b), 32'd0);
        checkOutput({tag, "_eng_data"},  32'(bus.eng_data),  32'd0);
        checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_out_gcd"},   32'(bus.out_gcd),   32'd0);
        checkOutput({tag, "_out_err"},   32'(bus.out_err),   32'd0);
        checkOutput({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        int base;
        int loadsBefore;
        int qBefore;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        #1 rst_n = 1'b0;
        #1 checkResetOutputs("reset");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Normal run through the engine.
        $display("[TB] scenario 1: (48,18)");
        engDelay = 10;
        loadData.delete();
        loadSel.delete();
        loadCyc.delete();
        applyStimulus(16'd48, 16'd18);
        waitOutputs(1);
        checkResult("s1_gcd", 16'd6, 1'b0);
        checkOutput("s1_loads", loadData.size(), 2);
        if (loadData.size() == 2) begin
            checkOutput("s1_loadA",  32'(loadData[0]), 32'd48);
            checkOutput("s1_selA",   32'(loadSel[0]),  32'd0);
            checkOutput("s1_loadB",  32'(loadData[1]), 32'd18);
            checkOutput("s1_selB",   32'(loadSel[1]),  32'd1);
            checkOutput("s1_consec", loadCyc[1] - loadCyc[0], 1);
        end

        // Zero operands bypass the engine.
        $display("[TB] scenario 2: zero operands");
        loadData.delete();
        applyStimulus(16'd0, 16'd9);
        waitOutputs(1);
        checkResult("s2_zero_a", 16'd9, 1'b0);
        applyStimulus(16'd7, 16'd0);
        waitOutputs(1);
        checkResult("s2_zero_b", 16'd7, 1'b0);
        applyStimulus(16'd0, 16'd0);
        waitOutputs(1);
        checkResult("s2_zero_both", 16'd0, 1'b1);
        checkOutput("s2_no_start", loadData.size(), 0);

        // Backpressure: first result held, FIFO fills, then drains in order.
        $display("[TB] scenario 3: backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(16'd12, 16'd8);
        applyStimulus(16'd35, 16'd14);
        applyStimulus(16'd9, 16'd6);
        checkOutput("s3_in_ready_full", 32'(bus.in_ready), 32'd0);
        waitCycles(30);
        checkOutput("s3_held_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("s3_held_gcd",   32'(bus.out_gcd),   32'd4);
        checkOutput("s3_still_full", 32'(bus.in_ready),  32'd0);
        checkOutput("s3_busy",       32'(bus.busy),      32'd1);
        bus.out_ready = 1'b1;
        waitOutputs(3);
        checkResult("s3_r0", 16'd4, 1'b0);
        checkResult("s3_r1", 16'd7, 1'b0);
        checkResult("s3_r2", 16'd3, 1'b0);

        // Timeout when done never arrives, then the queued pair runs normally.
        $display("[TB] scenario 4: timeout");
        stuckA = 16'd20;
        applyStimulus(16'd20, 16'd5);
        applyStimulus(16'd15, 16'd10);
        waitOutputs(1);
        checkOutput("s4_timeout_latency", validRiseCyc - lastLoadBCyc - 1, TIMEOUT);
        checkResult("s4_timeout", 16'd0, 1'b1);
        waitOutputs(1);
        checkResult("s4_next", 16'd5, 1'b0);

        // Reset in the middle of a run with pairs queued.
        $display("[TB] scenario 5: reset mid-run");
        loadData.delete();
        applyStimulus(16'd20, 16'd5);
        applyStimulus(16'd12, 16'd8);
        applyStimulus(16'd35, 16'd14);
        for (int i = 0; i < 200 && loadData.size() < 2; i++) waitCycles(1);
        waitCycles(5);
        checkOutput("s5_busy_before", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("s5_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        qBefore     = outQ.size();
        loadsBefore = loadData.size();
        waitCycles(3 * TIMEOUT);
        checkOutput("s5_no_output", outQ.size(), qBefore);
        checkOutput("s5_no_loads",  loadData.size(), loadsBefore);
        checkOutput("s5_idle",      32'(bus.busy), 32'd0);
        applyStimulus(16'd21, 16'd14);
        waitOutputs(qBefore + 1);
        checkResult("s5_after", 16'd7, 1'b0);

        // Stale done in IDLE, then a continuous stream across full/empty boundaries.
        $display("[TB] scenario 6: stale done and streaming");
        qBefore = outQ.size();
        waitCycles(20);
        checkOutput("s6_stale_done_high", 32'(bus.eng_done), 32'd1);
        checkOutput("s6_no_spurious",     outQ.size(), qBefore);
        checkOutput("s6_out_valid_low",   32'(bus.out_valid), 32'd0);
        engDelay = 3;
        loadData.delete();
        applyStimulus(16'd12, 16'd8);
        applyStimulus(16'd0, 16'd5);
        applyStimulus(16'd35, 16'd14);
        applyStimulus(16'd9, 16'd6);
        applyStimulus(16'd48, 16'd18);
        waitOutputs(5);
        checkResult("s6_r0", 16'd4, 1'b0);
        checkResult("s6_r1", 16'd5, 1'b0);
        checkResult("s6_r2", 16'd7, 1'b0);
        checkResult("s6_r3", 16'd3, 1'b0);
        checkResult("s6_r4", 16'd6, 1'b0);
        waitCycles(10);
        checkOutput("s6_load_count", loadData.size(), 8);
        checkOutput("s6_no_extra",   outQ.size(), 0);
        checkOutput("s6_idle",       32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
